// File: rtl/dzcpu_trace_buffer.sv
`timescale 1ns/1ps
// On-chip trace capture for the DZCPU/MMU pair: records fetch, filtered MMU
// write and end-of-flow events into a buffer that is drained over valid/ready.
module dzcpu_trace_buffer #(
    parameter int DEPTH   = 64,
    parameter int NUM_WIN = 2
) (
    input  logic                       iClock,
    input  logic                       iReset_n,
    input  logic                       iEnable,
    input  logic                       iCircular,
    input  logic                       iClear,
    input  logic                       iFetchValid,
    input  logic [15:0]                iPc,
    input  logic [7:0]                 iOpcode,
    input  logic                       iMemWe,
    input  logic [15:0]                iMemAddr,
    input  logic [7:0]                 iMemData,
    input  logic                       iEof,
    input  logic [NUM_WIN-1:0]         iWinEn,
    input  logic [16*NUM_WIN-1:0]      iWinLo,
    input  logic [16*NUM_WIN-1:0]      iWinHi,
    output logic                       oRdValid,
    output logic [31:0]                oRdData,
    input  logic                       iRdReady,
    output logic [$clog2(DEPTH):0]     oCount,
    output logic                       oFrozen,
    output logic [7:0]                 oDropCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FROZEN  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   head_reg, head_next;
    logic [AW-1:0]   tail_reg, tail_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [5:0]      delta_reg, delta_next;
    logic [7:0]      drop_reg, drop_next;
    logic [15:0]     last_pc_reg, last_pc_next;
    logic [31:0]     mem [DEPTH];

    logic [NUM_WIN-1:0] win_hit;
    logic               write_ok;
    logic               frozen;
    logic               capture_on;
    logic               want_push;
    logic               full;
    logic               pop;
    logic               blocked;
    logic               push;
    logic [1:0]         num_evts;
    logic [1:0]         drop_inc;
    logic [8:0]         drop_sum;
    logic [1:0]         evt_type;
    logic [15:0]        evt_addr;
    logic [7:0]         evt_data;
    logic [31:0]        entry;

    // An inverted window (lo > hi) naturally fails both comparisons' conjunction.
    generate
        for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_win
            assign win_hit[gi] = iWinEn[gi]
                               && (iMemAddr >= iWinLo[16*gi +: 16])
                               && (iMemAddr <= iWinHi[16*gi +: 16]);
        end
    endgenerate

    assign write_ok   = iMemWe && ((iWinEn == '0) || (|win_hit));
    assign frozen     = (state_reg == ST_FROZEN);
    assign capture_on = iEnable && !frozen && !iClear;
    assign num_evts   = {1'b0, write_ok} + {1'b0, iFetchValid} + {1'b0, iEof};
    assign want_push  = capture_on && (num_evts != 2'd0);
    assign full       = (count_reg == FULL_COUNT);
    assign pop        = (count_reg != '0) && iRdReady && !iClear;
    // Fill-once full buffer only accepts a push when a pop frees a slot first.
    assign blocked    = full && !iCircular && !pop;
    assign push       = want_push && !blocked;

    always_comb begin
        evt_type = 2'b10;
        evt_addr = last_pc_reg;
        evt_data = 8'h00;
        if (write_ok) begin
            evt_type = 2'b01;
            evt_addr = iMemAddr;
            evt_data = iMemData;
        end else if (iFetchValid) begin
            evt_type = 2'b00;
            evt_addr = iPc;
            evt_data = iOpcode;
        end
    end

    assign entry = {evt_type, delta_reg, evt_addr, evt_data};

    always_comb begin
        drop_inc = 2'd0;
        if (iClear) begin
            drop_inc = 2'd0;
        end else if (frozen) begin
            drop_inc = num_evts;
        end else if (capture_on) begin
            drop_inc = push ? (num_evts - 2'd1) : num_evts;
        end
    end

    assign drop_sum = {1'b0, drop_reg} + {7'b0, drop_inc};

    always_comb begin
        head_next    = head_reg;
        tail_next    = tail_reg;
        count_next   = count_reg;
        delta_next   = (delta_reg == 6'd63) ? delta_reg : delta_reg + 6'd1;
        drop_next    = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        last_pc_next = last_pc_reg;
        if (iClear) begin
            head_next    = '0;
            tail_next    = '0;
            count_next   = '0;
            delta_next   = '0;
            drop_next    = '0;
            last_pc_next = '0;
        end else begin
            // A full push overwrites the head slot, so head moves exactly once
            // whether or not a pop coincides.
            if (pop || (push && full)) begin
                head_next = head_reg + AW'(1);
            end
            if (push) begin
                tail_next  = tail_reg + AW'(1);
                delta_next = 6'd1;
                if (!write_ok && iFetchValid) begin
                    last_pc_next = iPc;
                end
            end
            if (push && !full && !pop) begin
                count_next = count_reg + CW'(1);
            end else if (!push && pop) begin
                count_next = count_reg - CW'(1);
            end
        end
    end

    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_reg   <= ST_IDLE;
            head_reg    <= '0;
            tail_reg    <= '0;
            count_reg   <= '0;
            delta_reg   <= '0;
            drop_reg    <= '0;
            last_pc_reg <= '0;
        end else begin
            state_reg   <= state_next;
            head_reg    <= head_next;
            tail_reg    <= tail_next;
            count_reg   <= count_next;
            delta_reg   <= delta_next;
            drop_reg    <= drop_next;
            last_pc_reg <= last_pc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_CAPTURE: begin
                if (iClear) begin
                    state_next = ST_IDLE;
                end else if ((push && !iCircular && count_next == FULL_COUNT)
                             || (want_push && blocked)) begin
                    state_next = ST_FROZEN;
                end else begin
                    state_next = iEnable ? ST_CAPTURE : ST_IDLE;
                end
            end
            ST_FROZEN: begin
                state_next = iClear ? ST_IDLE : ST_FROZEN;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        oFrozen = (state_reg == ST_FROZEN);
    end

    always_ff @(posedge iClock) begin
        if (push) begin
            mem[tail_reg] <= entry;
        end
    end

    assign oRdValid   = (count_reg != '0);
    assign oRdData    = mem[head_reg];
    assign oCount     = count_reg;
    assign oDropCount = drop_reg;

endmodule

// File: tb/tb_dzcpu_trace_buffer.sv
`timescale 1ns/1ps
// Self-checking bench for dzcpu_trace_buffer: table-driven capture vectors with
// a scoreboard queue, plus hand sequences for fill-once, circular and reset.
module tb_dzcpu_trace_buffer;

    logic        iClock = 1'b0;
    logic        iReset_n;
    logic        iEnable, iCircular, iClear;
    logic        iFetchValid, iMemWe, iEof, iRdReady;
    logic [15:0] iPc, iMemAddr;
    logic [7:0]  iOpcode, iMemData;
    logic [1:0]  iWinEn;
    logic [31:0] iWinLo, iWinHi;
    logic        oRdValid, oFrozen;
    logic [31:0] oRdData;
    logic [6:0]  oCount;
    logic [7:0]  oDropCount;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 iClock = ~iClock;

    dzcpu_trace_buffer #(.DEPTH(64), .NUM_WIN(2)) dut (
        .iClock(iClock), .iReset_n(iReset_n), .iEnable(iEnable),
        .iCircular(iCircular), .iClear(iClear), .iFetchValid(iFetchValid),
        .iPc(iPc), .iOpcode(iOpcode), .iMemWe(iMemWe), .iMemAddr(iMemAddr),
        .iMemData(iMemData), .iEof(iEof), .iWinEn(iWinEn), .iWinLo(iWinLo),
        .iWinHi(iWinHi), .oRdValid(oRdValid), .oRdData(oRdData),
        .iRdReady(iRdReady), .oCount(oCount), .oFrozen(oFrozen),
        .oDropCount(oDropCount)
    );

    typedef struct {
        int          gap;
        logic [1:0]  win_en;
        logic        fetch;
        logic [15:0] pc;
        logic [7:0]  op;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        eof;
        logic        cap;
        logic [31:0] word;
        int          drops;
    } vec_t;

    vec_t        vecs [15];
    logic [31:0] sb [$];
    logic [23:0] pcq [$];

    function automatic vec_t mk(int gap, logic [1:0] win_en, logic fetch,
                                logic [15:0] pc, logic [7:0] op, logic we,
                                logic [15:0] addr, logic [7:0] data, logic eof,
                                logic cap, logic [31:0] word, int drops);
        vec_t v;
        v.gap = gap; v.win_en = win_en; v.fetch = fetch; v.pc = pc; v.op = op;
        v.we = we; v.addr = addr; v.data = data; v.eof = eof; v.cap = cap;
        v.word = word; v.drops = drops;
        return v;
    endfunction

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic idle_inputs();
        iFetchValid = 1'b0; iMemWe = 1'b0; iEof = 1'b0;
        iRdReady = 1'b0; iClear = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] exp_low;
        iReset_n = 1'b0; iEnable = 1'b0; iCircular = 1'b0;
        idle_inputs();
        iPc = '0; iOpcode = '0; iMemAddr = '0; iMemData = '0;
        iWinEn = 2'b00;
        iWinLo = {16'h2000, 16'hFF40};   // window 1 is inverted: never matches
        iWinHi = {16'h1000, 16'hFF4B};

        //         gap win fe pc       op     we addr     data   eof cap word          drops
        vecs[0]  = mk(5,  2'b00, 1, 16'h0100, 8'h00, 0, 16'h0000, 8'h00, 0, 1, 32'h05010000, 0);
        vecs[1]  = mk(0,  2'b01, 0, 16'h0000, 8'h00, 1, 16'hFF47, 8'hFC, 0, 1, 32'h41FF47FC, 0);
        vecs[2]  = mk(0,  2'b01, 0, 16'h0000, 8'h00, 1, 16'h8000, 8'h11, 0, 0, 32'h0,        0);
        vecs[3]  = mk(0,  2'b01, 0, 16'h0000, 8'h00, 1, 16'hFF40, 8'h22, 0, 1, 32'h42FF4022, 0);
        vecs[4]  = mk(0,  2'b01, 0, 16'h0000, 8'h00, 1, 16'hFF4B, 8'h33, 0, 1, 32'h41FF4B33, 0);
        vecs[5]  = mk(0,  2'b01, 0, 16'h0000, 8'h00, 1, 16'hFF4C, 8'h44, 0, 0, 32'h0,        0);
        vecs[6]  = mk(0,  2'b01, 0, 16'h0000, 8'h00, 1, 16'hFF3F, 8'h55, 0, 0, 32'h0,        0);
        vecs[7]  = mk(0,  2'b10, 0, 16'h0000, 8'h00, 1, 16'h1800, 8'h5A, 0, 0, 32'h0,        0);
        vecs[8]  = mk(0,  2'b11, 1, 16'h1234, 8'hAB, 1, 16'hFF45, 8'h66, 1, 1, 32'h44FF4566, 2);
        vecs[9]  = mk(0,  2'b00, 1, 16'h0200, 8'h3E, 0, 16'h0000, 8'h00, 0, 1, 32'h0102003E, 2);
        vecs[10] = mk(2,  2'b00, 0, 16'h0000, 8'h00, 0, 16'h0000, 8'h00, 1, 1, 32'h83020000, 2);
        vecs[11] = mk(0,  2'b00, 1, 16'h0300, 8'h01, 0, 16'h0000, 8'h00, 1, 1, 32'h01030001, 3);
        vecs[12] = mk(0,  2'b00, 0, 16'h0000, 8'h00, 0, 16'h0000, 8'h00, 1, 1, 32'h81030000, 3);
        vecs[13] = mk(70, 2'b00, 1, 16'hBEEF, 8'h99, 0, 16'h0000, 8'h00, 0, 1, 32'h3FBEEF99, 3);
        vecs[14] = mk(0,  2'b00, 0, 16'h0000, 8'h00, 1, 16'h8000, 8'h77, 0, 1, 32'h41800077, 3);

        repeat (3) step();
        check("reset_valid", 32'(oRdValid), 32'd0);
        check("reset_count", 32'(oCount), 32'd0);
        check("reset_frozen", 32'(oFrozen), 32'd0);
        check("reset_drops", 32'(oDropCount), 32'd0);

        iReset_n = 1'b1;
        iEnable  = 1'b1;

        for (int i = 0; i < 15; i++) begin
            idle_inputs();
            iWinEn = vecs[i].win_en;
            repeat (vecs[i].gap) step();
            iFetchValid = vecs[i].fetch; iPc = vecs[i].pc; iOpcode = vecs[i].op;
            iMemWe = vecs[i].we; iMemAddr = vecs[i].addr; iMemData = vecs[i].data;
            iEof = vecs[i].eof;
            step();
            if (vecs[i].cap) sb.push_back(vecs[i].word);
            $display("vec %0d: fetch=%0b we=%0b eof=%0b count=%0d drops=%0d",
                     i, vecs[i].fetch, vecs[i].we, vecs[i].eof, oCount, oDropCount);
            check($sformatf("vec%0d_count", i), 32'(oCount), 32'(sb.size()));
            check($sformatf("vec%0d_drops", i), 32'(oDropCount), 32'(vecs[i].drops));
        end
        idle_inputs();
        check("head_first_fetch", oRdData, 32'h05010000);

        while (sb.size() > 0) begin
            logic [31:0] exp_word;
            exp_word = sb.pop_front();
            check("drain_valid", 32'(oRdValid), 32'd1);
            check("drain_word", oRdData, exp_word);
            $display("pop: data=%08h", oRdData);
            iRdReady = 1'b1;
            step();
        end
        iRdReady = 1'b0;
        check("drained_valid", 32'(oRdValid), 32'd0);
        check("drained_count", 32'(oCount), 32'd0);

        iClear = 1'b1; step(); iClear = 1'b0;
        check("clear_drops", 32'(oDropCount), 32'd0);

        // Fill-once: 70 fetches into a 64-entry buffer
        iCircular = 1'b0;
        for (int i = 0; i < 70; i++) begin
            iFetchValid = 1'b1; iPc = 16'(i); iOpcode = 8'(i) ^ 8'hA5;
            step();
        end
        idle_inputs();
        $display("fill-once: count=%0d frozen=%0b drops=%0d", oCount, oFrozen, oDropCount);
        check("fill_frozen", 32'(oFrozen), 32'd1);
        check("fill_count", 32'(oCount), 32'd64);
        check("fill_drops", 32'(oDropCount), 32'd6);
        check("fill_head", 32'(oRdData[23:0]), 32'h0000A5);
        iRdReady = 1'b1; step(); iRdReady = 1'b0;
        check("fill_pop_count", 32'(oCount), 32'd63);
        check("fill_pop_frozen", 32'(oFrozen), 32'd1);
        check("fill_pop_head", 32'(oRdData[23:0]), 32'h0001A4);
        iFetchValid = 1'b1; iPc = 16'h7777; step(); iFetchValid = 1'b0;
        check("frozen_drop", 32'(oDropCount), 32'd7);
        check("frozen_count", 32'(oCount), 32'd63);
        iClear = 1'b1; iFetchValid = 1'b1; step(); idle_inputs();
        check("clear_count", 32'(oCount), 32'd0);
        check("clear_frozen", 32'(oFrozen), 32'd0);
        check("clear_drops2", 32'(oDropCount), 32'd0);
        check("clear_valid", 32'(oRdValid), 32'd0);

        // Circular: oldest entries are overwritten
        iCircular = 1'b1;
        for (int i = 0; i < 70; i++) begin
            iFetchValid = 1'b1; iPc = 16'(i); iOpcode = 8'(i);
            step();
            pcq.push_back({16'(i), 8'(i)});
            if (pcq.size() > 64) void'(pcq.pop_front());
        end
        idle_inputs();
        check("circ_count", 32'(oCount), 32'd64);
        check("circ_drops", 32'(oDropCount), 32'd0);
        check("circ_frozen", 32'(oFrozen), 32'd0);
        check("circ_head_pc", 32'(oRdData[23:8]), 32'd6);

        // Full circular buffer: push and pop in the same cycle
        iFetchValid = 1'b1; iPc = 16'h0100; iOpcode = 8'h5A; iRdReady = 1'b1;
        exp_low = pcq.pop_front();
        check("circ_pushpop_word", 32'(oRdData[23:0]), 32'(exp_low));
        pcq.push_back({16'h0100, 8'h5A});
        step();
        idle_inputs();
        check("circ_pushpop_count", 32'(oCount), 32'd64);
        check("circ_pushpop_head", 32'(oRdData[23:8]), 32'd7);

        while (pcq.size() > 0) begin
            exp_low = pcq.pop_front();
            check("circ_drain", 32'(oRdData[23:0]), 32'(exp_low));
            $display("circ pop: pc=%04h op=%02h", oRdData[23:8], oRdData[7:0]);
            iRdReady = 1'b1;
            step();
        end
        iRdReady = 1'b0;
        check("circ_drained", 32'(oCount), 32'd0);

        // Reset asserted mid-stream
        iWinEn = 2'b00;
        for (int i = 0; i < 3; i++) begin
            iFetchValid = 1'b1; iPc = 16'(16'h0400 + i); step();
        end
        iMemWe = 1'b1; iMemAddr = 16'h9000; iEof = 1'b1; step();
        idle_inputs();
        check("pre_reset_drops", 32'(oDropCount), 32'd2);
        check("pre_reset_count", 32'(oCount), 32'd4);
        iReset_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(oRdValid), 32'd0);
        check("async_reset_count", 32'(oCount), 32'd0);
        check("async_reset_frozen", 32'(oFrozen), 32'd0);
        check("async_reset_drops", 32'(oDropCount), 32'd0);
        step();
        iReset_n = 1'b1;
        iFetchValid = 1'b1; iPc = 16'hCAFE; iOpcode = 8'h12;
        step();
        idle_inputs();
        check("post_reset_count", 32'(oCount), 32'd1);
        check("post_reset_word", oRdData, 32'h00CAFE12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
